// File: rtl/rb_arb_pkg.sv
// Shared definitions for the register-bank access arbiter.
//   arb_state_t      : arbiter FSM states
//   K_RD_ABORT_DATA  : read data returned to a requester whose read timed out
//   K_*_DEF          : default parameter values used by rb_access_arbiter
package rb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_WR = 2'd1,
    ISSUE_RD = 2'd2,
    WAIT_RD  = 2'd3
  } arb_state_t;

  localparam int K_N_REQ_DEF      = 2;
  localparam int K_ADDR_W_DEF     = 8;
  localparam int K_DATA_W_DEF     = 16;
  localparam int K_RD_TIMEOUT_DEF = 15;

  // Timeout counter width covers RD_TIMEOUT up to 255.
  localparam int K_TMO_W = 8;

  // Wide enough for any practical DATA_W; users truncate to DATA_W.
  localparam int                     K_DATA_W_MAX    = 64;
  localparam logic [K_DATA_W_MAX-1:0] K_RD_ABORT_DATA = '1;

endpackage

// File: rtl/rb_rr_pick.sv
// Round-robin requester picker (purely combinational).
//   pend      in  : one bit per requester with any pending access
//   rr_ptr    in  : index where the search starts
//   grant_oh  out : one-hot grant (all zero when nothing pending)
//   grant_idx out : index of the granted requester
//   any       out : at least one requester pending
module rb_rr_pick #(
  parameter int N_REQ = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_REQ-1:0] pend,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant_oh,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = PTR_W'((int'(rr_ptr) + off) % N_REQ);
      if (!any && pend[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
    grant_oh = any ? (N_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/rb_access_arbiter.sv
// Shares one register-bank write/read channel pair between N_REQ requesters.
// Requester strobes are latched into per-requester slots, granted in
// round-robin order (write before read within a requester) and serialised
// onto the bank. Read data is routed back to the issuer; a bank that never
// answers is cut off after RD_TIMEOUT cycles with all-ones data.
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   sif_wr_req_*                 : requester write channels (flattened, N_REQ slices)
//   sif_rd_req_read/addr         : requester read strobes and addresses
//   sif_rd_req_data/valid        : read responses back to each requester
//   mif_wr_rb_*                  : bank write channel
//   mif_rd_rb_read/addr          : bank read strobe and address
//   mif_rd_rb_data/valid         : bank read response
//   o_overrun                    : pulse when a strobe overwrote a pending slot
//   o_rd_timeout                 : pulse when a requester's read was aborted
module rb_access_arbiter
  import rb_arb_pkg::*;
#(
  parameter int N_REQ      = K_N_REQ_DEF,
  parameter int ADDR_W     = K_ADDR_W_DEF,
  parameter int DATA_W     = K_DATA_W_DEF,
  parameter int RD_TIMEOUT = K_RD_TIMEOUT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         sif_wr_req_write,
  input  logic [N_REQ*ADDR_W-1:0]  sif_wr_req_addr,
  input  logic [N_REQ*DATA_W-1:0]  sif_wr_req_data,
  input  logic [N_REQ*DATA_W-1:0]  sif_wr_req_bmask,
  input  logic [N_REQ-1:0]         sif_rd_req_read,
  input  logic [N_REQ*ADDR_W-1:0]  sif_rd_req_addr,
  output logic [N_REQ*DATA_W-1:0]  sif_rd_req_data,
  output logic [N_REQ-1:0]         sif_rd_req_valid,
  output logic                     mif_wr_rb_write,
  output logic [ADDR_W-1:0]        mif_wr_rb_addr,
  output logic [DATA_W-1:0]        mif_wr_rb_data,
  output logic [DATA_W-1:0]        mif_wr_rb_bmask,
  output logic                     mif_rd_rb_read,
  output logic [ADDR_W-1:0]        mif_rd_rb_addr,
  input  logic [DATA_W-1:0]        mif_rd_rb_data,
  input  logic                     mif_rd_rb_valid,
  output logic [N_REQ-1:0]         o_overrun,
  output logic [N_REQ-1:0]         o_rd_timeout
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [DATA_W-1:0] ABORT_DATA = K_RD_ABORT_DATA[DATA_W-1:0];

  // Slot contents gathered from the generate loop
  logic [N_REQ-1:0]  wr_pend;
  logic [N_REQ-1:0]  rd_pend;
  logic [ADDR_W-1:0] slot_wr_addr  [N_REQ];
  logic [DATA_W-1:0] slot_wr_data  [N_REQ];
  logic [DATA_W-1:0] slot_wr_bmask [N_REQ];
  logic [ADDR_W-1:0] slot_rd_addr  [N_REQ];

  // Per-requester response data, held until that requester's next read ends
  logic [DATA_W-1:0] rsp_data_q [N_REQ];

  // Control
  arb_state_t         state_q, state_d;
  logic [K_TMO_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0]   gnt_q, gnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]   wr_clr, rd_clr;
  logic               issue_wr, issue_rd, rd_done, rd_abort;

  logic [N_REQ-1:0]   pick_oh;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;

  // ---- Capture slots: one pending write and one pending read per requester
  for (genvar i = 0; i < N_REQ; i++) begin : g_slot
    logic              wr_pend_q, rd_pend_q, ovr_q;
    logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
    logic [DATA_W-1:0] wr_data_q, wr_bmask_q;
    logic              wr_stb, rd_stb;

    assign wr_stb = sif_wr_req_write[i];
    assign rd_stb = sif_rd_req_read[i];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        wr_pend_q  <= 1'b0;
        rd_pend_q  <= 1'b0;
        ovr_q      <= 1'b0;
        wr_addr_q  <= '0;
        wr_data_q  <= '0;
        wr_bmask_q <= '0;
        rd_addr_q  <= '0;
      end else begin
        // A strobe landing on the very edge its slot is being issued is a
        // fresh request, not an overwrite.
        ovr_q <= (wr_stb && wr_pend_q && !wr_clr[i]) ||
                 (rd_stb && rd_pend_q && !rd_clr[i]);
        if (wr_stb) begin
          wr_pend_q  <= 1'b1;
          wr_addr_q  <= sif_wr_req_addr[i*ADDR_W +: ADDR_W];
          wr_data_q  <= sif_wr_req_data[i*DATA_W +: DATA_W];
          wr_bmask_q <= sif_wr_req_bmask[i*DATA_W +: DATA_W];
        end else if (wr_clr[i]) begin
          wr_pend_q <= 1'b0;
        end
        if (rd_stb) begin
          rd_pend_q <= 1'b1;
          rd_addr_q <= sif_rd_req_addr[i*ADDR_W +: ADDR_W];
        end else if (rd_clr[i]) begin
          rd_pend_q <= 1'b0;
        end
      end
    end

    assign wr_pend[i]       = wr_pend_q;
    assign rd_pend[i]       = rd_pend_q;
    assign slot_wr_addr[i]  = wr_addr_q;
    assign slot_wr_data[i]  = wr_data_q;
    assign slot_wr_bmask[i] = wr_bmask_q;
    assign slot_rd_addr[i]  = rd_addr_q;
    assign o_overrun[i]     = ovr_q;
    assign sif_rd_req_data[i*DATA_W +: DATA_W] = rsp_data_q[i];
  end

  // ---- Grant selection
  rb_rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .pend      (wr_pend | rd_pend),
    .rr_ptr    (rr_q),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .any       (pick_any)
  );

  // ---- FSM next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    wr_clr   = '0;
    rd_clr   = '0;
    issue_wr = 1'b0;
    issue_rd = 1'b0;
    rd_done  = 1'b0;
    rd_abort = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d = pick_idx;
          rr_d  = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
          if (|(wr_pend & pick_oh)) begin
            issue_wr = 1'b1;
            wr_clr   = pick_oh;
            state_d  = ISSUE_WR;
          end else begin
            issue_rd = 1'b1;
            rd_clr   = pick_oh;
            state_d  = ISSUE_RD;
          end
        end
      end
      ISSUE_WR: state_d = IDLE;
      ISSUE_RD: begin
        cnt_d   = K_TMO_W'(RD_TIMEOUT);
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        // valid is still honoured on the cycle the counter sits at zero
        if (mif_rd_rb_valid) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          rd_abort = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM / control registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
    end
  end

  // ---- Registered bank and requester outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mif_wr_rb_write  <= 1'b0;
      mif_wr_rb_addr   <= '0;
      mif_wr_rb_data   <= '0;
      mif_wr_rb_bmask  <= '0;
      mif_rd_rb_read   <= 1'b0;
      mif_rd_rb_addr   <= '0;
      sif_rd_req_valid <= '0;
      o_rd_timeout     <= '0;
      for (int r = 0; r < N_REQ; r++) begin
        rsp_data_q[r] <= '0;
      end
    end else begin
      mif_wr_rb_write  <= issue_wr;
      mif_rd_rb_read   <= issue_rd;
      sif_rd_req_valid <= '0;
      o_rd_timeout     <= '0;
      if (issue_wr) begin
        mif_wr_rb_addr  <= slot_wr_addr[pick_idx];
        mif_wr_rb_data  <= slot_wr_data[pick_idx];
        mif_wr_rb_bmask <= slot_wr_bmask[pick_idx];
      end
      if (issue_rd) begin
        mif_rd_rb_addr <= slot_rd_addr[pick_idx];
      end
      if (rd_done || rd_abort) begin
        sif_rd_req_valid[gnt_q] <= 1'b1;
        rsp_data_q[gnt_q]       <= rd_done ? mif_rd_rb_data : ABORT_DATA;
      end
      if (rd_abort) begin
        o_rd_timeout[gnt_q] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rb_access_arbiter.sv
// Directed testbench for rb_access_arbiter (N_REQ=2, RD_TIMEOUT=4) with a
// transaction-level reference model compared on every cycle, plus literal
// expectations at key points of each scenario.
module tb_rb_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    wr_stb = '0;
  logic [N*AW-1:0] wr_addr = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N*DW-1:0] wr_bmask = '0;
  logic [N-1:0]    rd_stb = '0;
  logic [N*AW-1:0] rd_addr = '0;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_valid;
  logic            m_wr;
  logic [AW-1:0]   m_waddr;
  logic [DW-1:0]   m_wdata, m_wbmask;
  logic            m_rd;
  logic [AW-1:0]   m_raddr;
  logic [DW-1:0]   bank_data = '0;
  logic            bank_valid = 1'b0;
  logic [N-1:0]    ovr, tmo;

  int n_chk = 0;
  int n_fail = 0;

  rb_access_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_TIMEOUT(TO)
  ) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .sif_wr_req_write (wr_stb),
    .sif_wr_req_addr  (wr_addr),
    .sif_wr_req_data  (wr_data),
    .sif_wr_req_bmask (wr_bmask),
    .sif_rd_req_read  (rd_stb),
    .sif_rd_req_addr  (rd_addr),
    .sif_rd_req_data  (rsp_data),
    .sif_rd_req_valid (rsp_valid),
    .mif_wr_rb_write  (m_wr),
    .mif_wr_rb_addr   (m_waddr),
    .mif_wr_rb_data   (m_wdata),
    .mif_wr_rb_bmask  (m_wbmask),
    .mif_rd_rb_read   (m_rd),
    .mif_rd_rb_addr   (m_raddr),
    .mif_rd_rb_data   (bank_data),
    .mif_rd_rb_valid  (bank_valid),
    .o_overrun        (ovr),
    .o_rd_timeout     (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              mdl_on = 1'b0;
  int              ecount = 0;
  bit              p_wr [N];
  bit              p_rd [N];
  logic [AW-1:0]   s_waddr [N];
  logic [DW-1:0]   s_wdata [N];
  logic [DW-1:0]   s_wbmask [N];
  logic [AW-1:0]   s_raddr [N];
  int              rr = 0;
  int              free_at = 0;
  bit              rbusy = 1'b0;
  int              rown = 0, rfirst = 0, rlast = 0;
  logic            e_wr, e_rd;
  logic [AW-1:0]   e_waddr, e_raddr;
  logic [DW-1:0]   e_wdata, e_wbmask;
  logic [DW-1:0]   e_rdata [N];
  logic [N-1:0]    e_rval, e_ovr, e_tmo;

  task automatic model_step();
    bit cw [N];
    bit cr [N];
    bit found;
    int g;
    ecount++;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        p_wr[i] = 0; p_rd[i] = 0;
        s_waddr[i] = '0; s_wdata[i] = '0; s_wbmask[i] = '0; s_raddr[i] = '0;
        e_rdata[i] = '0;
      end
      rr = 0; rbusy = 0; free_at = ecount + 1;
      e_wr = 0; e_waddr = '0; e_wdata = '0; e_wbmask = '0;
      e_rd = 0; e_raddr = '0; e_rval = '0; e_ovr = '0; e_tmo = '0;
      mdl_on = 1'b1;
      return;
    end
    e_wr = 0; e_rd = 0; e_rval = '0; e_ovr = '0; e_tmo = '0;
    for (int i = 0; i < N; i++) begin cw[i] = 0; cr[i] = 0; end
    if (rbusy) begin
      if (ecount >= rfirst) begin
        if (bank_valid) begin
          e_rval[rown] = 1'b1; e_rdata[rown] = bank_data;
          rbusy = 0; free_at = ecount + 1;
        end else if (ecount == rlast) begin
          e_rval[rown] = 1'b1; e_tmo[rown] = 1'b1; e_rdata[rown] = 16'hFFFF;
          rbusy = 0; free_at = ecount + 1;
        end
      end
    end else if (ecount >= free_at) begin
      found = 0; g = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && (p_wr[(rr + k) % N] || p_rd[(rr + k) % N])) begin
          found = 1; g = (rr + k) % N;
        end
      end
      if (found) begin
        rr = (g + 1) % N;
        if (p_wr[g]) begin
          e_wr = 1; e_waddr = s_waddr[g]; e_wdata = s_wdata[g]; e_wbmask = s_wbmask[g];
          cw[g] = 1; free_at = ecount + 2;
        end else begin
          e_rd = 1; e_raddr = s_raddr[g]; cr[g] = 1;
          rbusy = 1; rown = g; rfirst = ecount + 2; rlast = ecount + 2 + TO;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (wr_stb[i]) begin
        if (p_wr[i] && !cw[i]) e_ovr[i] = 1'b1;
        p_wr[i] = 1; s_waddr[i] = wr_addr[i*AW +: AW];
        s_wdata[i] = wr_data[i*DW +: DW]; s_wbmask[i] = wr_bmask[i*DW +: DW];
      end else if (cw[i]) p_wr[i] = 0;
      if (rd_stb[i]) begin
        if (p_rd[i] && !cr[i]) e_ovr[i] = 1'b1;
        p_rd[i] = 1; s_raddr[i] = rd_addr[i*AW +: AW];
      end else if (cr[i]) p_rd[i] = 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (mdl_on) begin
      chk("cyc_bank_write", m_wr, e_wr);
      chk("cyc_bank_waddr", m_waddr, e_waddr);
      chk("cyc_bank_wdata", m_wdata, e_wdata);
      chk("cyc_bank_wbmask", m_wbmask, e_wbmask);
      chk("cyc_bank_read", m_rd, e_rd);
      chk("cyc_bank_raddr", m_raddr, e_raddr);
      chk("cyc_rsp_valid", rsp_valid, e_rval);
      chk("cyc_overrun", ovr, e_ovr);
      chk("cyc_rd_timeout", tmo, e_tmo);
      for (int i = 0; i < N; i++)
        chk($sformatf("cyc_rsp_data%0d", i), rsp_data[i*DW +: DW], e_rdata[i]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m);
    wr_stb[r] = 1'b1;
    wr_addr[r*AW +: AW] = a;
    wr_data[r*DW +: DW] = d;
    wr_bmask[r*DW +: DW] = m;
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    rd_stb[r] = 1'b1;
    rd_addr[r*AW +: AW] = a;
  endtask

  task automatic clr();
    wr_stb = '0;
    rd_stb = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk("reset_bank", {m_wr, m_waddr, m_wdata, m_wbmask, m_rd, m_raddr}, 64'd0);
    chk("reset_req", {rsp_data, rsp_valid, ovr, tmo}, 64'd0);
    rst = 1'b0;

    // single write
    set_wr(0, 8'h12, 16'hBEEF, 16'hFFFF); tick(); clr();
    chk("sw_no_overrun", ovr, 2'b00);
    tick();
    chk("sw_strobe", m_wr, 1'b1);
    chk("sw_addr", m_waddr, 8'h12);
    chk("sw_data", m_wdata, 16'hBEEF);
    chk("sw_bmask", m_wbmask, 16'hFFFF);
    tick();
    chk("sw_strobe_low", m_wr, 1'b0);
    chk("sw_addr_hold", m_waddr, 8'h12);
    repeat (2) tick();

    // contention after reset: req0 then req1, pointer back at 0
    rst = 1'b1; tick(); rst = 1'b0;
    set_wr(0, 8'h20, 16'h1111, 16'h00FF); set_wr(1, 8'h21, 16'h2222, 16'hFF00); tick(); clr();
    tick();
    chk("cont_first", {m_wr, m_waddr}, {1'b1, 8'h20});
    tick();
    chk("cont_gap", m_wr, 1'b0);
    tick();
    chk("cont_second", {m_wr, m_waddr, m_wdata, m_wbmask}, {1'b1, 8'h21, 16'h2222, 16'hFF00});
    tick();
    set_wr(0, 8'h22, 16'h3333, 16'hFFFF); set_wr(1, 8'h23, 16'h4444, 16'hFFFF); tick(); clr();
    tick();
    chk("cont_ptr0_first", {m_wr, m_waddr}, {1'b1, 8'h22});
    tick(); tick();
    chk("cont_ptr0_second", {m_wr, m_waddr}, {1'b1, 8'h23});
    tick();

    // read routing to req1
    set_rd(1, 8'h05); tick(); clr();
    tick();
    chk("rr_bank_read", {m_rd, m_raddr}, {1'b1, 8'h05});
    repeat (3) tick();
    bank_valid = 1'b1; bank_data = 16'h1234; tick(); bank_valid = 1'b0;
    chk("rr_valid", rsp_valid, 2'b10);
    chk("rr_data1", rsp_data[DW +: DW], 16'h1234);
    tick();
    chk("rr_valid_low", rsp_valid, 2'b00);
    chk("rr_data1_hold", rsp_data[DW +: DW], 16'h1234);

    // timeout on req0
    set_rd(0, 8'h33); tick(); clr();
    tick();
    chk("to_bank_read", {m_rd, m_raddr}, {1'b1, 8'h33});
    repeat (5) tick();
    chk("to_not_yet", tmo, 2'b00);
    tick();
    chk("to_pulse", tmo, 2'b01);
    chk("to_valid", rsp_valid, 2'b01);
    chk("to_data0", rsp_data[0 +: DW], 16'hFFFF);
    tick();
    chk("to_pulse_end", {tmo, rsp_valid}, 4'b0000);

    // overrun on req1 while req0's read is outstanding
    set_rd(0, 8'h40); tick(); clr();
    tick(); tick();
    set_wr(1, 8'h50, 16'h0001, 16'hFFFF); tick();
    set_wr(1, 8'h50, 16'h0002, 16'hFFFF); tick(); clr();
    chk("ov_pulse", ovr, 2'b10);
    tick();
    chk("ov_pulse_end", ovr, 2'b00);
    bank_valid = 1'b1; bank_data = 16'hABCD; tick(); bank_valid = 1'b0;
    chk("ov_rd_rsp", {rsp_valid, rsp_data[0 +: DW]}, {2'b01, 16'hABCD});
    tick();
    chk("ov_write_last", {m_wr, m_waddr, m_wdata}, {1'b1, 8'h50, 16'h0002});
    repeat (2) tick();

    // strobe on the same edge its slot is issued
    set_wr(0, 8'h60, 16'hAAAA, 16'hFFFF); tick();
    set_wr(0, 8'h61, 16'hBBBB, 16'hFFFF); tick(); clr();
    chk("same_edge_issue", {m_wr, m_waddr}, {1'b1, 8'h60});
    chk("same_edge_no_ovr", ovr, 2'b00);
    tick();
    tick();
    chk("same_edge_second", {m_wr, m_waddr, m_wdata}, {1'b1, 8'h61, 16'hBBBB});
    tick();

    // write before read within one requester
    set_wr(0, 8'h70, 16'h0C0C, 16'h0F0F); set_rd(0, 8'h71); tick(); clr();
    tick();
    chk("wfirst_write", {m_wr, m_rd, m_waddr}, {1'b1, 1'b0, 8'h70});
    tick(); tick();
    chk("wfirst_read", {m_rd, m_raddr}, {1'b1, 8'h71});
    tick();
    bank_valid = 1'b1; bank_data = 16'h7777; tick(); bank_valid = 1'b0;
    chk("wfirst_rsp", {rsp_valid, rsp_data[0 +: DW]}, {2'b01, 16'h7777});
    tick();

    // reset in the middle of a read, bank answers after release
    set_rd(1, 8'h60); tick(); clr();
    tick();
    chk("rst_mid_read_issued", m_rd, 1'b1);
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    bank_valid = 1'b1; bank_data = 16'h5555; tick(); bank_valid = 1'b0;
    chk("rst_mid_no_valid", rsp_valid, 2'b00);
    tick();
    chk("rst_mid_bank", {m_wr, m_waddr, m_wdata, m_wbmask, m_rd, m_raddr}, 64'd0);
    chk("rst_mid_req", {rsp_data, rsp_valid, ovr, tmo}, 64'd0);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rb_access_arbiter.md
# rb_access_arbiter

Shares the single register-bank write and read channel pair between `N_REQ` requesters, such as the SPI bridge and an internal sequencer. Each requester issues one-cycle read/write strobes exactly as it would toward the register bank. The arbiter latches them, grants in round-robin order, and serialises accesses onto the bank. Read data is routed back to the issuing requester, and a bounded timeout protects against a bank that never answers.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `ADDR_W`, 8, register address width
- `DATA_W`, 16, register data width
- `RD_TIMEOUT`, 15, cycles to wait for bank read `valid` before aborting (1..255)
- `i_clk`  in  1  main clock; the block uses one clock.
- `i_rst`  in  1  reset; synchronous and active-high.
- `sif_wr_req[N_REQ]`  `reg_wrchan_if.slave`  -  requester write channels: write, addr, data, bmask.
- `sif_rd_req[N_REQ]`  `reg_rdchan_if.slave`  -  requester read channels: read, addr in; data, valid out.
- `mif_wr_rb`  `reg_wrchan_if.master`  -  register bank write channel.
- `mif_rd_rb`  `reg_rdchan_if.master`  -  register bank read channel.
- `o_overrun`  out  N_REQ  one-cycle pulse per requester when a new strobe overwrote a still-pending request.
- `o_rd_timeout`  out  N_REQ  one-cycle pulse per requester when its read was aborted by timeout.

## Operation
- **Capture.** Per requester, one pending-write slot (addr, data, bmask) and one pending-read slot (addr).
  - A strobe loads its slot and sets the pending flag.
  - A strobe into an already-set slot overwrites it and pulses `o_overrun[i]`.
- **Round-robin pointer `rr_ptr`.** Reset value 0.
  - Grant goes to the first requester with any pending flag, searching `rr_ptr`, `rr_ptr+1`, … modulo N_REQ.
  - After each grant, `rr_ptr` = (granted+1) mod N_REQ.
- **Within one requester,** a pending write is issued before a pending read.
- **FSM states:**
  - `IDLE`: if any flag is pending → `ISSUE_WR` or `ISSUE_RD` for the granted request.
  - `ISSUE_WR`: `mif_wr_rb.write`=1 for exactly one cycle with the latched addr/data/bmask; clear the flag → `IDLE`.
  - `ISSUE_RD`: `mif_rd_rb.read`=1 for exactly one cycle with the latched addr; clear the flag; load the timeout counter → `WAIT_RD`.
  - `WAIT_RD`: on `mif_rd_rb.valid`, register `mif_rd_rb.data` into `sif_rd_req[g].data` and pulse `sif_rd_req[g].valid` → `IDLE`.
    - The counter decrements every cycle. If it reaches 0 without `valid`, pulse `o_rd_timeout[g]` and `sif_rd_req[g].valid`, with data = all-ones → `IDLE`.
- **Simultaneous events:**
  - A strobe arriving in the same cycle its slot is being cleared by issue wins: the flag stays set with the new contents, and `o_overrun` is not pulsed.
  - A `mif_rd_rb.valid` outside `WAIT_RD` is ignored.
- **Output holding:**
  - `sif_rd_req[i].data` holds its last value until that requester's next read completes.
  - Master addr/data hold their last issued values between strobes.

## Timing
- All outputs are registered.
- **Reset values:** all strobes, valids, `o_overrun`, `o_rd_timeout` = 0; all addr/data = 0; bmask = 0; FSM = `IDLE`; `rr_ptr` = 0; all pending flags = 0.
- **Reset mid-operation:** in-flight accesses are dropped, and no response valid is emitted for them.
- **Write latency:** strobe sampled at edge k → flag set after edge k → grant at edge k+1 → `mif_wr_rb.write` high in the cycle after edge k+1. This is 2 cycles when uncontended.
- **Read latency:** bank read strobe after edge k+1; bank `valid` sampled at edge m → requester `valid` high in the cycle after edge m.
- **Throughput:** each write occupies 2 cycles (`ISSUE_WR`, `IDLE`).
- **Bounds:** with all requesters busy, a request waits at most N_REQ×2 grants before issue. Each grant costs at most `RD_TIMEOUT`+3 cycles.
- **Strobe rule:** strobes are single-cycle. A level held high is treated as a new strobe each cycle, which overwrites and raises overrun.

## Structure
- Package `rb_arb_pkg`: FSM state enum `arb_state_t`, `K_RD_ABORT_DATA` (all-ones), default parameter constants.
- Sub-module `rb_rr_pick`: N_REQ-bit pending vector plus `rr_ptr` in → one-hot grant and grant index out.
  - Combinational search only; `rr_ptr` lives in the parent.
- Capture slots are a generate loop in the parent.

## Test plan
- **Single write:** req0 write addr 0x12 data 0xBEEF bmask 0xFFFF → one bank write strobe 2 cycles later with those values; no overrun.
- **Contention:** req0 and req1 write in the same cycle after reset → bank sees req0 first, then req1 two cycles later; `rr_ptr` ends at 0.
- **Read routing:** req1 reads 0x05 while the bank returns 0x1234 three cycles after its strobe → `sif_rd_req[1]` valid pulses once with 0x1234; `sif_rd_req[0]` valid stays low.
- **Timeout:** the bank never asserts valid with `RD_TIMEOUT`=4 → `o_rd_timeout[0]` and req0 valid pulse with data 0xFFFF; FSM returns to `IDLE`.
- **Overrun:** req1 writes 0x01 then 0x02 on consecutive cycles while `WAIT_RD` serves req0 → `o_overrun[1]` pulses once; only 0x02 reaches the bank.
- **Reset mid-read:** `i_rst` asserted in `WAIT_RD` and the bank valid arrives after release → no requester valid pulses; all outputs are at reset values.
